// File: rtl/full_xor_n8.sv
// Full-XOR unmasking of 8 Boolean shares through a 3-layer refreshed tree.
// Latency 1 cycle, full throughput, no backpressure; ena=0 freezes the output register.
module full_xor_n8 #(
  parameter int K_WIDTH  = 32,
  parameter int N_SHARES = 8,
  localparam int LOG_K   = $clog2(N_SHARES + 1) - 1,
  localparam int RANDNUM = LOG_K * (2 ** (LOG_K - 1)) + N_SHARES - (2 ** LOG_K)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ena,
  input  logic                          dvld,
  input  logic [RANDNUM*K_WIDTH-1:0]    rnd,
  input  logic [N_SHARES*K_WIDTH-1:0]   i_x,
  output logic [K_WIDTH-1:0]            o_z,
  output logic                          ovld
);

  logic [K_WIDTH-1:0] r    [RANDNUM];
  logic [K_WIDTH-1:0] v0   [8];
  logic [K_WIDTH-1:0] v1   [4];
  logic [K_WIDTH-1:0] v2   [2];
  logic [K_WIDTH-1:0] rsv;
  logic [K_WIDTH-1:0] tree_res;

  logic [K_WIDTH-1:0] o_z_d, o_z_q;
  logic               ovld_d, ovld_q;

  always_comb begin
    for (int m = 0; m < RANDNUM; m++) r[m] = rnd[m*K_WIDTH +: K_WIDTH];
    for (int i = 0; i < 8; i++) v0[i] = i_x[i*K_WIDTH +: K_WIDTH];
  end

  // Each layer folds share i with share i+h and adds a ring of fresh words,
  // so every word appears twice per layer and the layer XOR is preserved.
  always_comb begin
    for (int i = 0; i < 4; i++)
      v1[i] = v0[i] ^ v0[i+4] ^ r[i] ^ r[(i+1) % 4];
    for (int i = 0; i < 2; i++)
      v2[i] = v1[i] ^ v1[i+2] ^ r[4+i] ^ r[4+((i+1) % 2)];
  end

  // Reserved words enter as cancelling pairs until a refresh variant claims them.
  assign rsv      = r[6] ^ r[7] ^ r[9] ^ r[10] ^ r[11];
  assign tree_res = v2[0] ^ v2[1] ^ r[8] ^ r[8] ^ rsv ^ rsv;

  always_comb begin
    o_z_d  = o_z_q;
    ovld_d = ovld_q;
    if (ena) begin
      ovld_d = dvld;
      if (dvld) o_z_d = tree_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_z_q  <= '0;
      ovld_q <= 1'b0;
    end else begin
      o_z_q  <= o_z_d;
      ovld_q <= ovld_d;
    end
  end

  assign o_z  = o_z_q;
  assign ovld = ovld_q;

endmodule

// File: tb/tb_full_xor_n8.sv
// Randomised self-checking bench for full_xor_n8 against an XOR-of-shares model.
module tb_full_xor_n8;

  localparam int KW = 32;
  localparam int NS = 8;
  localparam int RN = 12;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic              dvld;
  logic [RN*KW-1:0]  rnd;
  logic [NS*KW-1:0]  i_x;
  logic [KW-1:0]     o_z;
  logic              ovld;

  logic [KW-1:0] xs [NS];
  logic [KW-1:0] rs [RN];
  logic [KW-1:0] m_z;
  logic          m_vld;
  logic [KW-1:0] frz_z;
  logic          frz_vld;
  int            n_checks;
  int            n_errors;

  full_xor_n8 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .dvld (dvld),
    .rnd  (rnd),
    .i_x  (i_x),
    .o_z  (o_z),
    .ovld (ovld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [KW-1:0] xor_all();
    logic [KW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NS; i++) acc = acc ^ xs[i];
    return acc;
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) i_x[i*KW +: KW] = xs[i];
    for (int m = 0; m < RN; m++) rnd[m*KW +: KW] = rs[m];
  endtask

  task automatic rand_rnd();
    for (int m = 0; m < RN; m++) rs[m] = $urandom;
    drive();
  endtask

  task automatic rand_x();
    for (int i = 0; i < NS; i++) xs[i] = $urandom;
    drive();
  endtask

  // Advance one cycle, update the model at the edge, check at the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst_n) begin
      m_z = '0;
      m_vld = 1'b0;
    end else if (ena) begin
      m_vld = dvld;
      if (dvld) m_z = xor_all();
    end
    @(negedge clk);
    chk({tag, "_z"}, o_z, m_z);
    chk({tag, "_vld"}, {31'b0, ovld}, {31'b0, m_vld});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_z = '0;
    m_vld = 1'b0;
    rst_n = 1'b0;
    ena = 1'b1;
    dvld = 1'b1;
    for (int i = 0; i < NS; i++) xs[i] = KW'(i + 1);
    rand_rnd();

    #9;
    chk("rst_z", o_z, 32'h0);
    chk("rst_vld", {31'b0, ovld}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    tick("inc");
    chk("inc_const", o_z, 32'h0000_0008);
    chk("inc_vld1", {31'b0, ovld}, 32'h1);

    for (int i = 0; i < NS; i++) xs[i] = '0;
    xs[0] = 32'hDEAD_BEEF;
    rand_rnd();
    tick("db1");
    chk("db1_const", o_z, 32'hDEAD_BEEF);
    xs[7] = 32'hDEAD_BEEF;
    rand_rnd();
    tick("db2");
    chk("db2_const", o_z, 32'h0000_0000);

    for (int c = 0; c < 10000; c++) begin
      rand_x();
      rand_rnd();
      dvld = ($urandom_range(0, 9) != 0);
      ena  = ($urandom_range(0, 19) != 0);
      tick("stream");
    end
    ena = 1'b1;
    dvld = 1'b1;

    rand_x();
    rand_rnd();
    tick("rnd_a");
    chk("rnd_a_ref", o_z, xor_all());
    rand_rnd();
    tick("rnd_b");
    chk("rnd_b_ref", o_z, xor_all());

    frz_z = m_z;
    frz_vld = m_vld;
    ena = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_x();
      rand_rnd();
      dvld = c[0];
      tick("frz");
      chk("frz_z_hold", o_z, frz_z);
      chk("frz_vld_hold", {31'b0, ovld}, {31'b0, frz_vld});
    end

    ena = 1'b1;
    dvld = 1'b0;
    rand_x();
    tick("nodv");
    chk("nodv_vld0", {31'b0, ovld}, 32'h0);
    chk("nodv_z_hold", o_z, frz_z);

    dvld = 1'b1;
    rand_x();
    tick("pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_z", o_z, 32'h0);
    chk("arst_vld", {31'b0, ovld}, 32'h0);
    tick("rst_hold");
    rst_n = 1'b1;
    rand_x();
    rand_rnd();
    tick("post_rst");
    chk("post_rst_vld", {31'b0, ovld}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
